multicycle_sequencer: RTL and testbench

Top-level control FSM of the multicycle core: fetches each instruction from memory, drives `ir_control` so the instruction register latches it, hands the decoded instruction to the execute datapath, and advances the PC. It sits between instruction memory, the instruction register and the execute unit. It owns PC sequencing, halt detection and fetch-fault detection, and counts retired instructions.

---
 rtl/multicycle_sequencer_pkg.sv | 28 ++
 rtl/fetch_watchdog.sv | 37 +++
 rtl/multicycle_sequencer.sv | 165 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// seq_pkg: shared types and constants for the multicycle sequencer.
//   seq_state_t  - FSM state encoding (also exported on the debug `state` port)
//   OPC_SYSTEM   - opcode that halts the sequencer
//   IR_*         - {clear, load} encodings for the instruction register
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] IR_HOLD  = 2'b00;
  localparam logic [1:0] IR_LOAD  = 2'b01;
  localparam logic [1:0] IR_CLEAR = 2'b10;

  // Instruction addresses must be word aligned.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts consecutive fetch-wait cycles.
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronously zero the counter (wins over enable)
//   enable     - count this cycle
//   expired    - this enabled cycle is the FETCH_TIMEOUT-th one; the owner
//                acts on the edge that ends it
module fetch_watchdog
  import seq_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The counter holds the number of already-completed counted cycles, so the
  // FETCH_TIMEOUT-th cycle is the one where it reads FETCH_TIMEOUT-1.
  localparam logic [7:0] LAST_COUNT = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign expired = enable && !clear && (count_reg == LAST_COUNT);

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: top-level control FSM of the multicycle core.
// Fetches an instruction, loads it into the instruction register, decodes the
// opcode fed back from it, starts the execute datapath and advances the PC.
//   clk, rst_n          - clock, asynchronous active-low reset
//   run                 - keep issuing instructions (sampled in IDLE / EXEC exit)
//   mem_req, mem_addr   - instruction fetch request and address (= pc)
//   mem_rvalid, mem_err - fetch response and error flag
//   ir_control          - {clear, load} for the instruction register
//   opcode              - instr_out[6:0] from the instruction register
//   ex_start            - one-cycle execute start pulse
//   ex_done             - execute complete (may coincide with ex_start)
//   ex_redirect,
//   ex_target           - take ex_target instead of pc+4 (qualified by ex_done)
//   pc, instret         - current instruction address, retired count
//   halted, fault       - sticky status flags
//   state               - current FSM state for debug
// Every output comes straight from a flop so ir_control never glitches.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic        mem_err,
  output logic [1:0]  ir_control,
  input  logic [6:0]  opcode,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  seq_state_t  state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instret_reg;
  logic        mem_req_reg;
  logic [1:0]  ir_control_reg;
  logic        ex_start_reg;
  logic        halted_reg;
  logic        fault_reg;

  logic        in_fetch;
  logic        wdog_expired;
  logic [31:0] pc_next;

  assign in_fetch = (state_reg == ST_FETCH);

  // Counter is held at zero outside FETCH, which clears it on every entry.
  fetch_watchdog #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_fetch),
    .enable  (in_fetch),
    .expired (wdog_expired)
  );

  assign pc_next = ex_redirect ? ex_target : (pc_reg + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      pc_reg         <= RESET_PC;
      instret_reg    <= '0;
      mem_req_reg    <= 1'b0;
      ir_control_reg <= IR_CLEAR;
      ex_start_reg   <= 1'b0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      // ex_start is a single-cycle pulse; only DECODE re-arms it.
      ex_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg      <= ST_FETCH;
            mem_req_reg    <= 1'b1;
            ir_control_reg <= IR_HOLD;
          end
        end
        ST_FETCH: begin
          if (mem_rvalid && !mem_err) begin
            state_reg      <= ST_LATCH;
            mem_req_reg    <= 1'b0;
            ir_control_reg <= IR_LOAD;
          end else if (mem_rvalid || wdog_expired) begin
            state_reg      <= ST_FAULT;
            mem_req_reg    <= 1'b0;
            ir_control_reg <= IR_CLEAR;
            fault_reg      <= 1'b1;
          end
        end
        ST_LATCH: begin
          state_reg      <= ST_DECODE;
          ir_control_reg <= IR_HOLD;
        end
        ST_DECODE: begin
          if (opcode == OPC_SYSTEM) begin
            state_reg  <= ST_HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg    <= ST_EXEC;
            ex_start_reg <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (ex_done) begin
            // The instruction retires even when its redirect target is bad.
            instret_reg <= instret_reg + 32'd1;
            if (ex_redirect && !is_word_aligned(ex_target)) begin
              state_reg      <= ST_FAULT;
              ir_control_reg <= IR_CLEAR;
              fault_reg      <= 1'b1;
            end else begin
              pc_reg <= pc_next;
              if (run) begin
                state_reg   <= ST_FETCH;
                mem_req_reg <= 1'b1;
              end else begin
                state_reg      <= ST_IDLE;
                ir_control_reg <= IR_CLEAR;
              end
            end
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        ST_FAULT: begin
          state_reg <= ST_FAULT;
        end
        default: begin
          // Unreachable encoding: park safely.
          state_reg      <= ST_FAULT;
          mem_req_reg    <= 1'b0;
          ir_control_reg <= IR_CLEAR;
          fault_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = pc_reg;
  assign ir_control = ir_control_reg;
  assign ex_start   = ex_start_reg;
  assign pc         = pc_reg;
  assign instret    = instret_reg;
  assign halted     = halted_reg;
  assign fault      = fault_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: self-checking bench for multicycle_sequencer.
// Expected fetch addresses are queued by each scenario and popped when the
// DUT raises mem_req; a small instruction-register model feeds opcode back.
module tb_multicycle_sequencer;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic        mem_err = 1'b0;
  logic [1:0]  ir_control;
  logic [6:0]  opcode;
  logic        ex_start;
  logic        ex_done = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halted;
  logic        fault;
  logic [2:0]  state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [31:0] exp_addr_q[$];
  logic [1:0]  ir_trace[$];
  int          req_cycles;
  int          load_cycles;

  logic [31:0] instr_in = 32'h0;
  logic [31:0] ir_reg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] SYS_INSTR = 32'h0000_0073;

  multicycle_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_err     (mem_err),
    .ir_control  (ir_control),
    .opcode      (opcode),
    .ex_start    (ex_start),
    .ex_done     (ex_done),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .pc          (pc),
    .instret     (instret),
    .halted      (halted),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction register model
  always @(posedge clk) begin
    if (ir_control == IR_CLEAR) ir_reg <= '0;
    else if (ir_control == IR_LOAD) ir_reg <= instr_in;
  end
  assign opcode = ir_reg[6:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void rec();
    ir_trace.push_back(ir_control);
    if (mem_req) req_cycles++;
    if (ir_control == IR_LOAD) load_cycles++;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    exp_addr_q.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Drives one instruction through memory and execute; records observations.
  task automatic serve(input int mem_wait, input int ex_wait, input logic err,
                       input logic [31:0] instr, input logic redir,
                       input logic [31:0] tgt, input logic drop_run,
                       output logic [31:0] addr, output int start_cyc,
                       output logic started);
    int n = 0;
    ir_trace.delete();
    req_cycles = 0;
    load_cycles = 0;
    started = 1'b0;
    addr = 32'hDEAD_BEEF;
    start_cyc = -1;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    if (!mem_req) begin
      compared++;
      mismatched++;
      $display("FAIL serve_wait: mem_req=%b, required 1 within 20 cycles", mem_req);
      return;
    end
    addr = mem_addr;
    start_cyc = cyc;
    for (int i = 0; i < mem_wait; i++) begin
      rec();
      step();
    end
    mem_rvalid = 1'b1;
    mem_err = err;
    instr_in = instr;
    rec();
    step();
    mem_rvalid = 1'b0;
    mem_err = 1'b0;
    if (err) return;
    rec();
    step();  // LATCH
    rec();
    step();  // DECODE
    if (!ex_start) return;
    started = 1'b1;
    if (drop_run) run = 1'b0;
    for (int i = 0; i < ex_wait; i++) begin
      rec();
      step();
    end
    ex_done = 1'b1;
    ex_redirect = redir;
    ex_target = tgt;
    rec();
    step();
    ex_done = 1'b0;
    ex_redirect = 1'b0;
    ex_target = 32'h0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    compared += 8;
    if (state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d, required %0d", state, ST_IDLE); end
    if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h, required 0", pc); end
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
    if (ir_control !== 2'b10) begin mismatched++; $display("FAIL reset_ir: got %b, required 10", ir_control); end
    if (ex_start !== 1'b0) begin mismatched++; $display("FAIL reset_ex_start: got %b, required 0", ex_start); end
    if (instret !== 32'h0) begin mismatched++; $display("FAIL reset_instret: got %0d, required 0", instret); end
    if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b, required 0", halted); end
    if (fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got %b, required 0", fault); end
    step();
    rst_n = 1'b1;
    step();
    compared++;
    if (state !== ST_IDLE || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_no_run: state=%0d mem_req=%b, required IDLE/0", state, mem_req);
    end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] addr, exp;
    int sc, prev_sc;
    logic started;
    logic [1:0] exp_ir[4];
    exp_ir[0] = 2'b00; exp_ir[1] = 2'b01; exp_ir[2] = 2'b00; exp_ir[3] = 2'b00;
    prev_sc = 0;
    run = 1'b1;
    for (int k = 0; k < 3; k++) exp_addr_q.push_back(32'(4 * k));
    for (int k = 0; k < 3; k++) begin
      serve(0, 0, 1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0, addr, sc, started);
      exp = exp_addr_q.pop_front();
      compared++;
      if (addr !== exp) begin mismatched++; $display("FAIL seq_addr[%0d]: got %h, required %h", k, addr, exp); end
      compared++;
      if (ir_trace.size() != 4) begin
        mismatched++;
        $display("FAIL seq_trace_len[%0d]: got %0d, required 4", k, ir_trace.size());
      end else begin
        for (int j = 0; j < 4; j++) begin
          compared++;
          if (ir_trace[j] !== exp_ir[j]) begin
            mismatched++;
            $display("FAIL seq_ir[%0d][%0d]: got %b, required %b", k, j, ir_trace[j], exp_ir[j]);
          end
        end
      end
      if (k > 0) begin
        compared++;
        if (sc - prev_sc != 4) begin mismatched++; $display("FAIL seq_spacing[%0d]: got %0d, required 4", k, sc - prev_sc); end
      end
      prev_sc = sc;
      $display("seq instr %0d addr=%h start_cyc=%0d", k, addr, sc);
    end
    compared++;
    if (instret !== 32'd3) begin mismatched++; $display("FAIL seq_instret: got %0d, required 3", instret); end
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd12) begin
      mismatched++;
      $display("FAIL seq_next_fetch: mem_req=%b addr=%h, required 1/0000000c", mem_req, mem_addr);
    end
    exp_addr_q.push_back(32'd12);
  endtask

  task automatic test_mem_wait();
    logic [31:0] addr, exp;
    int sc;
    logic started;
    serve(3, 0, 1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0, addr, sc, started);
    exp = exp_addr_q.pop_front();
    compared += 4;
    if (addr !== exp) begin mismatched++; $display("FAIL wait_addr: got %h, required %h", addr, exp); end
    if (req_cycles != 4) begin mismatched++; $display("FAIL wait_fetch_cycles: got %0d, required 4", req_cycles); end
    if (load_cycles != 1) begin mismatched++; $display("FAIL wait_load_count: got %0d, required 1", load_cycles); end
    if (instret !== 32'd4) begin mismatched++; $display("FAIL wait_instret: got %0d, required 4", instret); end
    $display("mem_wait addr=%h fetch_cycles=%0d", addr, req_cycles);
  endtask

  task automatic test_timeout();
    // Entered on the first FETCH cycle at pc=16 with rvalid withheld.
    for (int i = 0; i < 14; i++) step();
    compared++;
    if (fault !== 1'b0 || mem_req !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_early: fault=%b mem_req=%b, required 0/1", fault, mem_req);
    end
    step();
    compared += 5;
    if (fault !== 1'b1) begin mismatched++; $display("FAIL timeout_fault: got %b, required 1", fault); end
    if (ir_control !== 2'b10) begin mismatched++; $display("FAIL timeout_ir: got %b, required 10", ir_control); end
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL timeout_mem_req: got %b, required 0", mem_req); end
    if (state !== ST_FAULT) begin mismatched++; $display("FAIL timeout_state: got %0d, required %0d", state, ST_FAULT); end
    if (pc !== 32'd16) begin mismatched++; $display("FAIL timeout_pc: got %h, required 00000010", pc); end
    $display("timeout fault=%b state=%0d", fault, state);
  endtask

  task automatic test_fetch_err();
    logic [31:0] addr;
    int sc;
    logic started;
    do_reset();
    run = 1'b1;
    serve(1, 0, 1'b1, NOP_INSTR, 1'b0, 32'h0, 1'b0, addr, sc, started);
    compared += 3;
    if (fault !== 1'b1) begin mismatched++; $display("FAIL err_fault: got %b, required 1", fault); end
    if (state !== ST_FAULT) begin mismatched++; $display("FAIL err_state: got %0d, required %0d", state, ST_FAULT); end
    if (instret !== 32'd0) begin mismatched++; $display("FAIL err_instret: got %0d, required 0", instret); end
    $display("fetch_err fault=%b", fault);
  endtask

  task automatic test_redirect();
    logic [31:0] addr, exp;
    int sc;
    logic started;
    logic [31:0] tgts[4];
    logic        redirs[4];
    tgts[0] = 32'h100;       redirs[0] = 1'b1;
    tgts[1] = 32'hFFFF_FFFC; redirs[1] = 1'b1;
    tgts[2] = 32'h0;         redirs[2] = 1'b0;
    tgts[3] = 32'h102;       redirs[3] = 1'b1;
    do_reset();
    run = 1'b1;
    exp_addr_q.push_back(32'h0);
    for (int k = 0; k < 4; k++) begin
      serve(k % 2, 2 - (k % 2) * 2, 1'b0, NOP_INSTR, redirs[k], tgts[k], 1'b0, addr, sc, started);
      exp = exp_addr_q.pop_front();
      compared++;
      if (addr !== exp) begin mismatched++; $display("FAIL redir_addr[%0d]: got %h, required %h", k, addr, exp); end
      // Next address: taken target, or sequential with 32-bit wrap.
      exp_addr_q.push_back(redirs[k] ? tgts[k] : exp + 32'd4);
      $display("redirect instr %0d addr=%h target=%h", k, addr, tgts[k]);
    end
    compared += 4;
    if (fault !== 1'b1) begin mismatched++; $display("FAIL misalign_fault: got %b, required 1", fault); end
    if (pc !== 32'h0) begin mismatched++; $display("FAIL misalign_pc: got %h, required 00000000", pc); end
    if (instret !== 32'd4) begin mismatched++; $display("FAIL misalign_instret: got %0d, required 4", instret); end
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL misalign_mem_req: got %b, required 0", mem_req); end
    exp_addr_q.delete();
  endtask

  task automatic test_halt();
    logic [31:0] addr, exp;
    int sc;
    logic started;
    do_reset();
    run = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    serve(0, 0, 1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0, addr, sc, started);
    exp = exp_addr_q.pop_front();
    compared++;
    if (addr !== exp) begin mismatched++; $display("FAIL halt_addr0: got %h, required %h", addr, exp); end
    serve(0, 0, 1'b0, SYS_INSTR, 1'b0, 32'h0, 1'b0, addr, sc, started);
    exp = exp_addr_q.pop_front();
    compared += 4;
    if (addr !== exp) begin mismatched++; $display("FAIL halt_addr1: got %h, required %h", addr, exp); end
    if (started !== 1'b0) begin mismatched++; $display("FAIL halt_ex_start: got %b, required 0", started); end
    if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_flag: got %b, required 1", halted); end
    if (instret !== 32'd1) begin mismatched++; $display("FAIL halt_instret: got %0d, required 1", instret); end
    ex_done = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ex_done = 1'b0;
    compared += 3;
    if (state !== ST_HALT) begin mismatched++; $display("FAIL halt_sticky: got %0d, required %0d", state, ST_HALT); end
    if (ir_control !== 2'b00) begin mismatched++; $display("FAIL halt_ir: got %b, required 00", ir_control); end
    if (instret !== 32'd1 || mem_req !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_quiet: instret=%0d mem_req=%b, required 1/0", instret, mem_req);
    end
    $display("halt halted=%b instret=%0d", halted, instret);
  endtask

  task automatic test_async_reset();
    logic [31:0] addr;
    int sc;
    logic started;
    do_reset();
    run = 1'b1;
    serve(0, 0, 1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b0, addr, sc, started);
    compared++;
    if (mem_req !== 1'b1 || instret !== 32'd1) begin
      mismatched++;
      $display("FAIL arst_pre: mem_req=%b instret=%0d, required 1/1", mem_req, instret);
    end
    // Pulse reset in the middle of a FETCH cycle, well away from any edge.
    #2 rst_n = 1'b0;
    #1;
    compared += 6;
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL arst_mem_req: got %b, required 0", mem_req); end
    if (pc !== 32'h0) begin mismatched++; $display("FAIL arst_pc: got %h, required 0", pc); end
    if (instret !== 32'h0) begin mismatched++; $display("FAIL arst_instret: got %0d, required 0", instret); end
    if (ir_control !== 2'b10) begin mismatched++; $display("FAIL arst_ir: got %b, required 10", ir_control); end
    if (state !== ST_IDLE) begin mismatched++; $display("FAIL arst_state: got %0d, required %0d", state, ST_IDLE); end
    if (ex_start !== 1'b0) begin mismatched++; $display("FAIL arst_ex_start: got %b, required 0", ex_start); end
    step();
    rst_n = 1'b1;
    $display("async_reset state=%0d pc=%h", state, pc);
  endtask

  task automatic test_run_drop();
    logic [31:0] addr;
    int sc;
    logic started;
    do_reset();
    run = 1'b1;
    serve(1, 1, 1'b0, NOP_INSTR, 1'b0, 32'h0, 1'b1, addr, sc, started);
    compared += 4;
    if (started !== 1'b1) begin mismatched++; $display("FAIL drop_started: got %b, required 1", started); end
    if (instret !== 32'd1) begin mismatched++; $display("FAIL drop_instret: got %0d, required 1", instret); end
    if (pc !== 32'd4) begin mismatched++; $display("FAIL drop_pc: got %h, required 00000004", pc); end
    if (state !== ST_IDLE || ir_control !== 2'b10) begin
      mismatched++;
      $display("FAIL drop_idle: state=%0d ir=%b, required %0d/10", state, ir_control, ST_IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (mem_req !== 1'b0) begin mismatched++; $display("FAIL drop_mem_req[%0d]: got %b, required 0", i, mem_req); end
    end
    $display("run_drop state=%0d instret=%0d", state, instret);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_timeout();
    test_fetch_err();
    test_redirect();
    test_halt();
    test_async_reset();
    test_run_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
